// File: rtl/conv_ch_scheduler_pkg.sv
// Shared types and constants for the conv3x3 channel scheduler:
// FSM encoding, output FIFO depth and the channel-index width helper.
package conv_ch_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int FIFO_DEPTH = 2;

  // Channel index width; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_ch_scheduler_conv3x3.sv
// Single-cycle-latency 3x3 convolution engine: signed WI x WI products,
// sign-extended sum plus bias, ACCW-bit wrapping result. Synchronous reset.
module conv_ch_scheduler_conv3x3 #(
  parameter int WI   = 8,
  parameter int BW   = 32,
  parameter int ACCW = 32
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iInValid,
  input  logic [3*WI-1:0]   iWinRow1,
  input  logic [3*WI-1:0]   iWinRow2,
  input  logic [3*WI-1:0]   iWinRow3,
  input  logic [9*WI-1:0]   conv_weight,
  input  logic [BW-1:0]     conv_bias,
  output logic              oOutValid,
  output logic [ACCW-1:0]   oOutData
);

  logic [3*WI-1:0]        rows [3];
  logic signed [BW-1:0]   bias_s;
  logic signed [WI-1:0]   px;
  logic signed [WI-1:0]   wt;
  logic signed [2*WI-1:0] prod;
  logic signed [ACCW-1:0] sum;

  logic                   valid_q, valid_d;
  logic [ACCW-1:0]        data_q, data_d;

  assign rows   = '{iWinRow1, iWinRow2, iWinRow3};
  assign bias_s = conv_bias;

  // Pixel (r,c) sits at column c counted from the row MSBs; weight (r,c)
  // sits at index r*3+c counted from the LSBs.
  always_comb begin
    px   = '0;
    wt   = '0;
    prod = '0;
    sum  = ACCW'(bias_s);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px   = rows[r][(2-c)*WI +: WI];
        wt   = conv_weight[(r*3+c)*WI +: WI];
        prod = px * wt;
        sum  = sum + ACCW'(prod);
      end
    end
  end

  always_comb begin
    valid_d = iInValid;
    data_d  = data_q;
    if (iInValid) begin
      data_d = sum;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign oOutValid = valid_q;
  assign oOutData  = data_q;

endmodule

// File: rtl/conv_ch_scheduler.sv
// Holds one 3x3 window and replays it through a shared conv3x3 engine once per
// output channel, returning channel-tagged results via a credit-gated 2-entry FIFO.
module conv_ch_scheduler
  import conv_ch_scheduler_pkg::*;
#(
  parameter int WI   = 8,
  parameter int BW   = 32,
  parameter int ACCW = 32,
  parameter int NCH  = 4,
  localparam int CHW = ch_width(NCH)
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iWinValid,
  output logic              oWinReady,
  input  logic [3*WI-1:0]   iWinRow1,
  input  logic [3*WI-1:0]   iWinRow2,
  input  logic [3*WI-1:0]   iWinRow3,
  input  logic              iCfgWe,
  input  logic [CHW-1:0]    iCfgCh,
  input  logic [9*WI-1:0]   iCfgWeight,
  input  logic [BW-1:0]     iCfgBias,
  output logic              oCfgErr,
  output logic              oOutValid,
  input  logic              iOutReady,
  output logic [ACCW-1:0]   oOutData,
  output logic [CHW-1:0]    oOutCh,
  output logic              oOutLast,
  output logic              oBusy
);

  // Window handshake: a window transfers on a clock edge where iWinValid and
  // oWinReady are both high; result handshake likewise with oOutValid/iOutReady.

  state_e            state_q, state_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [3*WI-1:0]   row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;
  logic [9*WI-1:0]   wgt_q [NCH];
  logic [9*WI-1:0]   wgt_d [NCH];
  logic [BW-1:0]     bias_q [NCH];
  logic [BW-1:0]     bias_d [NCH];
  logic              inflight_q, inflight_d;
  logic [CHW-1:0]    tag_ch_q, tag_ch_d;
  logic              tag_last_q, tag_last_d;
  logic [ACCW-1:0]   fdata_q [FIFO_DEPTH];
  logic [ACCW-1:0]   fdata_d [FIFO_DEPTH];
  logic [CHW-1:0]    fch_q [FIFO_DEPTH];
  logic [CHW-1:0]    fch_d [FIFO_DEPTH];
  logic              flast_q [FIFO_DEPTH];
  logic              flast_d [FIFO_DEPTH];
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic              cfg_err_q, cfg_err_d;

  logic              win_acc, pop, push, issue, issue_ok, is_last, cfg_apply;
  logic [2:0]        credit;
  logic              eng_valid;
  logic [ACCW-1:0]   eng_data;

  assign oWinReady = (state_q == ST_IDLE);
  assign win_acc   = iWinValid && oWinReady;
  assign oOutValid = (count_q != 2'd0);
  assign pop       = oOutValid && iOutReady;
  assign push      = eng_valid;
  assign cfg_apply = iCfgWe && (state_q == ST_IDLE);
  assign is_last   = (ch_q == CHW'(NCH-1));

  // Slots already spoken for: queued results plus the one inside the engine,
  // less the one leaving this cycle. Issue only if one slot stays free.
  assign credit    = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue_ok  = (credit < 3'(FIFO_DEPTH));
  assign issue     = (state_q == ST_RUN) && issue_ok;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    row1_d     = row1_q;
    row2_d     = row2_q;
    row3_d     = row3_q;
    tag_ch_d   = tag_ch_q;
    tag_last_d = tag_last_q;
    inflight_d = issue;
    cfg_err_d  = iCfgWe && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (win_acc) begin
          row1_d  = iWinRow1;
          row2_d  = iWinRow2;
          row3_d  = iWinRow3;
          ch_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          tag_ch_d   = ch_q;
          tag_last_d = is_last;
          if (is_last) begin
            ch_d    = '0;
            state_d = ST_IDLE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wgt_d  = wgt_q;
    bias_d = bias_q;
    for (int k = 0; k < NCH; k++) begin
      if (cfg_apply && (iCfgCh == CHW'(k))) begin
        wgt_d[k]  = iCfgWeight;
        bias_d[k] = iCfgBias;
      end
    end
  end

  always_comb begin
    fdata_d  = fdata_q;
    fch_d    = fch_q;
    flast_d  = flast_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fdata_d[wr_ptr_q] = eng_data;
      fch_d[wr_ptr_q]   = tag_ch_q;
      flast_d[wr_ptr_q] = tag_last_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      row1_q     <= '0;
      row2_q     <= '0;
      row3_q     <= '0;
      inflight_q <= 1'b0;
      tag_ch_q   <= '0;
      tag_last_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        wgt_q[k]  <= '0;
        bias_q[k] <= '0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fdata_q[k] <= '0;
        fch_q[k]   <= '0;
        flast_q[k] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      row1_q     <= row1_d;
      row2_q     <= row2_d;
      row3_q     <= row3_d;
      inflight_q <= inflight_d;
      tag_ch_q   <= tag_ch_d;
      tag_last_q <= tag_last_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cfg_err_q  <= cfg_err_d;
      wgt_q      <= wgt_d;
      bias_q     <= bias_d;
      fdata_q    <= fdata_d;
      fch_q      <= fch_d;
      flast_q    <= flast_d;
    end
  end

  conv_ch_scheduler_conv3x3 #(
    .WI   (WI),
    .BW   (BW),
    .ACCW (ACCW)
  ) u_engine (
    .iClk        (iClk),
    .iRsn        (iRsn),
    .iInValid    (issue),
    .iWinRow1    (row1_q),
    .iWinRow2    (row2_q),
    .iWinRow3    (row3_q),
    .conv_weight (wgt_q[ch_q]),
    .conv_bias   (bias_q[ch_q]),
    .oOutValid   (eng_valid),
    .oOutData    (eng_data)
  );

  assign oOutData = fdata_q[rd_ptr_q];
  assign oOutCh   = fch_q[rd_ptr_q];
  assign oOutLast = flast_q[rd_ptr_q];
  assign oCfgErr  = cfg_err_q;
  assign oBusy    = (state_q != ST_IDLE) || oOutValid || inflight_q;

endmodule

// File: tb/tb_conv_ch_scheduler.sv
// Directed bench for conv_ch_scheduler: hand-computed results checked through
// immediate assertions plus an in-order scoreboard of delivered outputs.
module tb_conv_ch_scheduler;

  localparam int WI   = 8;
  localparam int BW   = 32;
  localparam int ACCW = 32;
  localparam int NCH  = 4;
  localparam int CHW  = 2;

  logic              iClk;
  logic              iRsn;
  logic              iWinValid;
  logic              oWinReady;
  logic [3*WI-1:0]   iWinRow1, iWinRow2, iWinRow3;
  logic              iCfgWe;
  logic [CHW-1:0]    iCfgCh;
  logic [9*WI-1:0]   iCfgWeight;
  logic [BW-1:0]     iCfgBias;
  logic              oCfgErr;
  logic              oOutValid;
  logic              iOutReady;
  logic [ACCW-1:0]   oOutData;
  logic [CHW-1:0]    oOutCh;
  logic              oOutLast;
  logic              oBusy;

  int n_tests;
  int n_fail;
  int cyc;

  logic [ACCW-1:0] exp_q[$];
  logic [CHW-1:0]  exp_ch_q[$];
  logic [ACCW-1:0] got_q[$];
  logic [CHW-1:0]  got_ch_q[$];
  logic            got_last_q[$];

  conv_ch_scheduler #(
    .WI(WI), .BW(BW), .ACCW(ACCW), .NCH(NCH)
  ) dut (
    .iClk       (iClk),
    .iRsn       (iRsn),
    .iWinValid  (iWinValid),
    .oWinReady  (oWinReady),
    .iWinRow1   (iWinRow1),
    .iWinRow2   (iWinRow2),
    .iWinRow3   (iWinRow3),
    .iCfgWe     (iCfgWe),
    .iCfgCh     (iCfgCh),
    .iCfgWeight (iCfgWeight),
    .iCfgBias   (iCfgBias),
    .oCfgErr    (oCfgErr),
    .oOutValid  (oOutValid),
    .iOutReady  (iOutReady),
    .oOutData   (oOutData),
    .oOutCh     (oOutCh),
    .oOutLast   (oOutLast),
    .oBusy      (oBusy)
  );

  // clock / reset
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc <= cyc + 1;

  // output monitor: a transfer happens at the next rising edge
  always @(negedge iClk) begin
    if (oOutValid && iOutReady) begin
      got_q.push_back(oOutData);
      got_ch_q.push_back(oOutCh);
      got_last_q.push_back(oOutLast);
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic [7:0] w, input int b);
    iCfgWe     = 1'b1;
    iCfgCh     = CHW'(ch);
    iCfgWeight = {9{w}};
    iCfgBias   = BW'(b);
    step();
    iCfgWe     = 1'b0;
  endtask

  task automatic set_window(input logic [7:0] p);
    iWinRow1 = {3{p}};
    iWinRow2 = {3{p}};
    iWinRow3 = {3{p}};
  endtask

  task automatic send_window(input string tag, input logic [7:0] p);
    set_window(p);
    iWinValid = 1'b1;
    check({tag, "_win_ready"}, longint'(oWinReady), 1);
    step();
    iWinValid = 1'b0;
  endtask

  task automatic expect_res(input int val, input int ch);
    exp_q.push_back(ACCW'(val));
    exp_ch_q.push_back(CHW'(ch));
  endtask

  // Wait for n results, then compare them in order against the expected queue.
  task automatic drain(input string tag, input int n);
    int waited;
    int m;
    waited = 0;
    while (got_q.size() < n && waited < 60) begin
      step();
      waited++;
    end
    repeat (4) step();
    check({tag, "_count"}, longint'(got_q.size()), longint'(n));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_data%0d", tag, i), longint'($signed(got_q[i])),
            longint'($signed(exp_q[i])));
      check($sformatf("%s_ch%0d", tag, i), longint'(got_ch_q[i]), longint'(exp_ch_q[i]));
      check($sformatf("%s_last%0d", tag, i), longint'(got_last_q[i]),
            longint'(exp_ch_q[i] == CHW'(NCH-1)));
    end
    got_q.delete();
    got_ch_q.delete();
    got_last_q.delete();
    exp_q.delete();
    exp_ch_q.delete();
  endtask

  initial begin
    int acc1, acc2, issues, waited;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    iRsn       = 1'b0;
    iWinValid  = 1'b0;
    iCfgWe     = 1'b0;
    iCfgCh     = '0;
    iCfgWeight = '0;
    iCfgBias   = '0;
    iOutReady  = 1'b1;
    set_window(8'd0);

    // reset values
    #2;
    check("rst_win_ready", longint'(oWinReady), 1);
    check("rst_out_valid", longint'(oOutValid), 0);
    check("rst_out_data",  longint'(oOutData), 0);
    check("rst_out_ch",    longint'(oOutCh), 0);
    check("rst_out_last",  longint'(oOutLast), 0);
    check("rst_cfg_err",   longint'(oCfgErr), 0);
    check("rst_busy",      longint'(oBusy), 0);
    #20;
    iRsn = 1'b1;
    step();

    // basic: bank[k] = weights k+1, bias k; window of 2s
    for (int k = 0; k < NCH; k++) cfg_write(k, 8'(k + 1), k);
    check("idle_cfg_err", longint'(oCfgErr), 0);
    send_window("basic", 8'd2);
    check("basic_busy_t1",   longint'(oBusy), 1);
    check("basic_valid_t1",  longint'(oOutValid), 0);
    step();
    check("basic_valid_t2",  longint'(oOutValid), 0);
    step();
    check("basic_valid_t3",  longint'(oOutValid), 1);
    check("basic_data_t3",   longint'($signed(oOutData)), 18);
    check("basic_ch_t3",     longint'(oOutCh), 0);
    expect_res(18, 0);
    expect_res(37, 1);
    expect_res(56, 2);
    expect_res(75, 3);
    drain("basic", 4);
    check("basic_idle_busy", longint'(oBusy), 0);

    // back-to-back windows of 1 then 3
    set_window(8'd1);
    iWinValid = 1'b1;
    check("b2b_ready1", longint'(oWinReady), 1);
    acc1 = cyc;
    step();
    set_window(8'd3);
    acc2 = -1;
    waited = 0;
    while (acc2 < 0 && waited < 20) begin
      if (oWinReady) acc2 = cyc;
      step();
      waited++;
    end
    iWinValid = 1'b0;
    check("b2b_accept_gap", longint'(acc2 - acc1), longint'(NCH + 1));
    for (int k = 0; k < NCH; k++) expect_res(9 * (k + 1) + k, k);
    for (int k = 0; k < NCH; k++) expect_res(27 * (k + 1) + k, k);
    drain("b2b", 8);

    // backpressure: only two issues while the sink stalls
    iOutReady = 1'b0;
    send_window("bp", 8'd2);
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      if (dut.issue) issues++;
      step();
    end
    check("bp_issues",    longint'(issues), 2);
    check("bp_valid",     longint'(oOutValid), 1);
    check("bp_head_ch",   longint'(oOutCh), 0);
    check("bp_head_data", longint'($signed(oOutData)), 18);
    iOutReady = 1'b1;
    expect_res(18, 0);
    expect_res(37, 1);
    expect_res(56, 2);
    expect_res(75, 3);
    drain("bp", 4);

    // config write while running is rejected
    send_window("cfgrun", 8'd2);
    cfg_write(0, 8'd7, 100);
    check("cfgrun_err_pulse", longint'(oCfgErr), 1);
    step();
    check("cfgrun_err_clear", longint'(oCfgErr), 0);
    expect_res(18, 0);
    expect_res(37, 1);
    expect_res(56, 2);
    expect_res(75, 3);
    drain("cfgrun", 4);

    // write in the accept cycle is used for that window; bank0 untouched
    iCfgWe     = 1'b1;
    iCfgCh     = 2'd1;
    iCfgWeight = {9{8'd5}};
    iCfgBias   = 32'd9;
    send_window("cfgacc", 8'd2);
    iCfgWe     = 1'b0;
    check("cfgacc_err", longint'(oCfgErr), 0);
    expect_res(18, 0);
    expect_res(99, 1);
    expect_res(56, 2);
    expect_res(75, 3);
    drain("cfgacc", 4);

    // signed arithmetic
    cfg_write(0, 8'hFF, 5);
    cfg_write(1, 8'd127, 0);
    send_window("sgn_a", 8'd127);
    expect_res(-1138, 0);
    expect_res(145161, 1);
    expect_res(3431, 2);
    expect_res(4575, 3);
    drain("sgn_a", 4);
    send_window("sgn_b", 8'h80);
    expect_res(1157, 0);
    expect_res(-146304, 1);
    expect_res(-3454, 2);
    expect_res(-4605, 3);
    drain("sgn_b", 4);

    // reset in the middle of a window
    send_window("rstrun", 8'd2);
    step();
    step();
    iRsn = 1'b0;
    #1;
    check("rstrun_win_ready", longint'(oWinReady), 1);
    check("rstrun_out_valid", longint'(oOutValid), 0);
    check("rstrun_out_data",  longint'(oOutData), 0);
    check("rstrun_out_ch",    longint'(oOutCh), 0);
    check("rstrun_out_last",  longint'(oOutLast), 0);
    check("rstrun_cfg_err",   longint'(oCfgErr), 0);
    check("rstrun_busy",      longint'(oBusy), 0);
    repeat (3) step();
    iRsn = 1'b1;
    repeat (8) step();
    check("rstrun_no_stale",  longint'(got_q.size()), 0);
    check("rstrun_valid_after", longint'(oOutValid), 0);
    check("rstrun_ready_after", longint'(oWinReady), 1);
    send_window("rstbank", 8'd2);
    for (int k = 0; k < NCH; k++) expect_res(0, k);
    drain("rstbank", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ch_scheduler.md
Name: conv_ch_scheduler

Overview:
- Time-multiplexes one conv3x3 engine across NCH output channels.
- Accepts one 3x3 input window through a valid/ready handshake and holds it.
- Issues the window to the engine once per output channel, each time with that channel's weights and bias from an internal config bank.
- Returns channel-tagged results through a 2-entry output FIFO with valid/ready; issue is credit-gated so no engine result is ever lost.

Parameters:
- WI, 8, pixel and weight width (signed).
- BW, 32, bias width.
- ACCW, 32, result width (ACCW >= 2*WI+4, ACCW >= BW).
- NCH, 4, output channels per window (>= 2). CHW = $clog2(NCH) is a localparam.

Ports:
- iClk  in  1  clock
- iRsn  in  1  asynchronous active-low reset
- iWinValid  in  1  window offered
- oWinReady  out  1  window accepted when both valid and ready are high
- iWinRow1 / iWinRow2 / iWinRow3  in  3*WI each  window rows, leftmost pixel in the MSBs
- iCfgWe  in  1  config write strobe
- iCfgCh  in  CHW  channel to write
- iCfgWeight  in  9*WI  {w22..w00}, w00 in bits [WI-1:0]
- iCfgBias  in  BW  channel bias
- oCfgErr  out  1  one-cycle pulse: write rejected
- oOutValid  out  1  result available
- iOutReady  in  1  downstream accepts
- oOutData  out  ACCW  signed conv result
- oOutCh  out  CHW  channel of oOutData
- oOutLast  out  1  result belongs to channel NCH-1
- oBusy  out  1  state != IDLE, or FIFO not empty, or engine result in flight

Behaviour:
- Reset (async, iRsn low): state IDLE, channel counter 0, FIFO empty, in-flight flag 0.
  - Reset output values: oWinReady=1, oOutValid=0, oOutData=0, oOutCh=0, oOutLast=0, oCfgErr=0, oBusy=0.
  - Weight/bias bank resets to all zeros.
  - Reset mid-RUN abandons the window and discards all results.
- FSM states:
  - IDLE: oWinReady=1. On accept, latch the three rows, ch=0, go to RUN.
  - RUN: oWinReady=0.
    - Each cycle with issue permitted: drive the engine's iInValid=1 with the latched rows and bank[ch]; ch++.
    - Issuing ch=NCH-1 returns to IDLE in the next state.
- Issue permission: fifo_count + inflight - pop < 2, where pop = oOutValid & iOutReady.
  - inflight = engine issued in the previous cycle (engine latency is 1 cycle).
  - The combinational path iOutReady -> engine iInValid is intentional.
- Tag register: captures {ch, ch==NCH-1} on each issue. It is written into the FIFO alongside the engine's oOutData whenever the engine's oOutValid is high.
- FIFO: 2 entries, in order.
  - oOutValid = !empty; outputs come from the head entry.
  - Simultaneous push and pop when full is legal; count is unchanged.
- Latency and throughput:
  - Window accepted at edge T: ch0 issued in cycle T+1; ch0 at oOutValid in cycle T+3.
  - With iOutReady held high: one result per cycle.
  - Back-to-back windows: one window every NCH+1 cycles.
- Arithmetic: handled entirely by the engine (signed WI x WI products, sign-extended sum + bias, ACCW bits, wraps on overflow). The block adds no rounding or saturation.
- Config:
  - Write takes effect at the clock edge in IDLE only.
  - iCfgWe while not IDLE: ignored, and oCfgErr pulses the next cycle.
  - A write in the same cycle as a window accept is applied, and the new values are used for that window.
- The window bank is not re-latched during RUN; row inputs are don't-care then.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_RUN), FIFO_DEPTH=2, and a helper function for the CHW width.
- One sub-module: the existing conv3x3 engine, instantiated once with WI/BW/ACCW passed through.
  - Its synchronous reset is tied to iRsn.
  - Its conv_weight/conv_bias are muxed from bank[ch].
- FIFO is inline; no separate module.

Test Plan:
- Basic: NCH=4, bank[k] = all weights (k+1), bias k; window all 2 -> outputs in order 18, 37, 56, 75 with oOutCh 0..3; oOutLast only on 75; first result 3 cycles after accept.
- Signed: bank[0] weights all -1, bias 5; window all 127 -> -1138; bank[1] weights all 127, window all -128, bias 0 -> -146304.
- Backpressure: iOutReady low -> exactly 2 engine issues, then the engine's iInValid stays 0 and oOutValid stays 1 holding ch0. Release -> remaining channels delivered in order with no loss or duplication.
- Back-to-back: iWinValid held high with windows of value 1 then 3, iOutReady high -> 8 results, with window 2 accepted exactly NCH+1 cycles after window 1.
- Config during RUN: iCfgWe mid-window -> oCfgErr pulses once and the bank is unchanged (check on the next window); a write in IDLE is used immediately.
- Reset mid-RUN: assert iRsn after ch1 issue -> all outputs at reset values asynchronously; after release no stale results appear, oWinReady=1, and the bank reads zero (next window gives bias-only 0 results).
